ttt_move_sequencer: RTL and testbench

//  Front-end controller for the tictactoe core. Synchronizes and debounces
//  the raw X/O buttons and the 9-bit position switches, and arbitrates

---
 rtl/ttt_move_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ttt_move_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_sequencer.sv
// Front-end for the tictactoe core: synchronises and debounces the X/O buttons and
// position switches, arbitrates presses and issues one move at a time over req/ack.
module ttt_move_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 16,
    parameter int FLASH_DIV       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_x_raw,
    input  logic       btn_o_raw,
    input  logic [8:0] sel_pos_raw,
    input  logic       turn_x,
    input  logic       turn_o,
    input  logic       move_ack,
    output logic       move_req,
    output logic       move_player,
    output logic [8:0] move_pos,
    output logic       bad_sel,
    output logic       ack_timeout,
    output logic       busy,
    output logic       flash_clk
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int FL_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_DIV - 1);

    typedef enum logic [1:0] {IDLE, ARM, REQ, HOLD} state_t;

    // Bit 1 carries the X button, bit 0 the O button.
    logic [1:0] btn_raw;
    logic [1:0] press;
    logic [1:0] released;
    assign btn_raw = {btn_x_raw, btn_o_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            meta_reg;
            logic            sync_reg;
            logic            prev_reg;
            logic [DB_W-1:0] cnt_reg;
            logic [DB_W-1:0] cnt_next;
            logic            changed;

            assign changed = (sync_reg != prev_reg);

            // Counts consecutive cycles at the current synced level, saturating.
            always_comb begin
                cnt_next = cnt_reg;
                if (changed) begin
                    cnt_next = DB_W'(1);
                end else if (cnt_reg != DB_MAX) begin
                    cnt_next = cnt_reg + DB_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                    cnt_reg  <= '0;
                end else begin
                    meta_reg <= btn_raw[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                    cnt_reg  <= cnt_next;
                end
            end

            assign press[gi]    = sync_reg && (cnt_next == DB_MAX) && (changed || (cnt_reg != DB_MAX));
            assign released[gi] = !sync_reg && !changed && (cnt_reg == DB_MAX);
        end
    endgenerate

    logic [8:0] sel_meta_reg;
    logic [8:0] sel_sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_meta_reg <= '0;
            sel_sync_reg <= '0;
        end else begin
            sel_meta_reg <= sel_pos_raw;
            sel_sync_reg <= sel_meta_reg;
        end
    end

    state_t          state_reg, state_next;
    logic            player_reg, player_next;
    logic [8:0]      pos_reg, pos_next;
    logic [TO_W-1:0] timer_reg, timer_next;
    logic            bad_sel_reg, bad_sel_next;
    logic            ack_timeout_reg, ack_timeout_next;
    logic            grant_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            player_reg      <= 1'b0;
            pos_reg         <= '0;
            timer_reg       <= '0;
            bad_sel_reg     <= 1'b0;
            ack_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            player_reg      <= player_next;
            pos_reg         <= pos_next;
            timer_reg       <= timer_next;
            bad_sel_reg     <= bad_sel_next;
            ack_timeout_reg <= ack_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        player_next      = player_reg;
        pos_next         = pos_reg;
        timer_next       = '0;
        bad_sel_next     = 1'b0;
        ack_timeout_next = 1'b0;
        grant_x          = 1'b1;
        case (state_reg)
            IDLE: begin
                if (|press) begin
                    // Simultaneous presses go to whoever's turn it is, X by default.
                    if (press[1] && press[0]) begin
                        grant_x = turn_x || !turn_o;
                    end else begin
                        grant_x = press[1];
                    end
                    player_next = grant_x;
                    pos_next    = sel_sync_reg;
                    if ($countones(sel_sync_reg) != 1) begin
                        bad_sel_next = 1'b1;
                        state_next   = HOLD;
                    end else begin
                        state_next = ARM;
                    end
                end
            end
            ARM: begin
                if (turn_x || turn_o) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                timer_next = timer_reg + TO_W'(1);
                if (move_ack) begin
                    state_next = HOLD;
                end else if (timer_reg == TO_LAST) begin
                    ack_timeout_next = 1'b1;
                    state_next       = HOLD;
                end
            end
            HOLD: begin
                if (&released) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic [FL_W-1:0] flash_cnt_reg;
    logic            flash_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_cnt_reg <= '0;
            flash_reg     <= 1'b0;
        end else if (flash_cnt_reg == FL_LAST) begin
            flash_cnt_reg <= '0;
            flash_reg     <= ~flash_reg;
        end else begin
            flash_cnt_reg <= flash_cnt_reg + FL_W'(1);
        end
    end

    assign move_req    = (state_reg == REQ);
    assign move_player = player_reg;
    assign move_pos    = pos_reg;
    assign bad_sel     = bad_sel_reg;
    assign ack_timeout = ack_timeout_reg;
    assign busy        = (state_reg != IDLE);
    assign flash_clk   = flash_reg;

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Scoreboard bench for ttt_move_sequencer: directed scenarios followed by randomized
// presses, with expected events derived from the press/turn/ack rules.
module tb_ttt_move_sequencer;
    localparam int DB = 4;
    localparam int TO = 16;
    localparam int FD = 8;
    localparam int K_MOVE = 0;
    localparam int K_BAD  = 1;
    localparam int K_TO   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_x_raw = 1'b0;
    logic       btn_o_raw = 1'b0;
    logic [8:0] sel_pos_raw = '0;
    logic       turn_x = 1'b0;
    logic       turn_o = 1'b0;
    logic       move_ack = 1'b0;
    logic       move_req;
    logic       move_player;
    logic [8:0] move_pos;
    logic       bad_sel;
    logic       ack_timeout;
    logic       busy;
    logic       flash_clk;

    always #5 clk = ~clk;

    ttt_move_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .ACK_TIMEOUT(TO),
        .FLASH_DIV(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_x_raw(btn_x_raw),
        .btn_o_raw(btn_o_raw),
        .sel_pos_raw(sel_pos_raw),
        .turn_x(turn_x),
        .turn_o(turn_o),
        .move_ack(move_ack),
        .move_req(move_req),
        .move_player(move_player),
        .move_pos(move_pos),
        .bad_sel(bad_sel),
        .ack_timeout(ack_timeout),
        .busy(busy),
        .flash_clk(flash_clk)
    );

    typedef struct {
        int         kind;
        logic       player;
        logic [8:0] pos;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic       req_prev = 1'b0;
    logic       player_prev = 1'b0;
    logic [8:0] pos_prev = '0;

    function automatic string kname(input int k);
        if (k == K_MOVE) return "move";
        if (k == K_BAD) return "bad_sel";
        return "ack_timeout";
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_event(input int kind);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: DUT raised %s, scoreboard expected nothing", kname(kind), kname(kind));
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            errors++;
            $display("FAIL event_kind: got %s, expected %s", kname(kind), kname(e.kind));
        end else if (kind == K_MOVE && (move_player !== e.player || move_pos !== e.pos)) begin
            errors++;
            $display("FAIL move_fields: got player=%0d pos=%03h, expected player=%0d pos=%03h",
                     move_player, move_pos, e.player, e.pos);
        end else begin
            $display("[%0t] %s ok player=%0d pos=%03h", $time, kname(kind), move_player, move_pos);
        end
    endtask

    // Monitor: every output event is matched against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (move_req && !req_prev) begin
                    expect_event(K_MOVE);
                end else if (move_req) begin
                    chk("req_stable", {22'd0, move_player, move_pos}, {22'd0, player_prev, pos_prev});
                end
                if (bad_sel) expect_event(K_BAD);
                if (ack_timeout) expect_event(K_TO);
            end
            req_prev    = move_req;
            player_prev = move_player;
            pos_prev    = move_pos;
        end
    end

    // who: 0 = X only, 1 = O only, 2 = both. d: cycles of REQ before ack (>= TO means no ack).
    task automatic do_move(input int who, input logic [8:0] sel, input logic tx, input logic to_,
                           input int d, input bit bounce, input int hold);
        exp_t e;
        bit   onehot;
        int   n;
        logic bx;
        logic bo;
        bx = (who != 1);
        bo = (who != 0);
        @(negedge clk);
        sel_pos_raw = sel;
        turn_x = tx;
        turn_o = to_;
        repeat (3) @(negedge clk);
        onehot = ($countones(sel) == 1);
        e.pos = sel;
        e.player = 1'b0;
        if (!onehot) begin
            e.kind = K_BAD;
            exp_q.push_back(e);
        end else begin
            e.kind = K_MOVE;
            if (who == 0) e.player = 1'b1;
            else if (who == 1) e.player = 1'b0;
            else e.player = (tx || !to_);
            exp_q.push_back(e);
            if (d >= TO) begin
                e.kind = K_TO;
                exp_q.push_back(e);
            end
        end
        if (bounce) begin
            btn_x_raw = bx; btn_o_raw = bo;
            @(negedge clk);
            btn_x_raw = 1'b0; btn_o_raw = 1'b0;
            @(negedge clk);
        end
        btn_x_raw = bx;
        btn_o_raw = bo;
        if (!onehot) begin
            repeat (16) @(negedge clk);
        end else begin
            if (!bounce && (tx || to_)) begin
                for (int k = 1; k <= DB + 3; k++) begin
                    @(posedge clk);
                    #1;
                    if (k == DB + 2) chk("latency_early", move_req, 0);
                    if (k == DB + 3) chk("latency_edge", move_req, 1);
                end
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 12 && !tx && !to_) turn_x = 1'b1;
            end while (!move_req && n < 40);
            chk("req_seen", move_req, 1);
            if (move_req) begin
                if (d < TO) begin
                    repeat (d) @(negedge clk);
                    move_ack = 1'b1;
                    @(negedge clk);
                    move_ack = 1'b0;
                    chk("req_drop_after_ack", move_req, 0);
                end else begin
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (move_req && n < TO + 4);
                    chk("req_timeout_cycles", n, TO);
                end
            end
        end
        repeat (hold) @(negedge clk);
        chk("busy_while_held", busy, 1);
        btn_x_raw = 1'b0;
        btn_o_raw = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 30);
        chk("idle_after_release", busy, 0);
    endtask

    task automatic reset_during_req();
        exp_t e;
        int   n;
        @(negedge clk);
        sel_pos_raw = 9'h100;
        turn_x = 1'b1;
        turn_o = 1'b0;
        repeat (3) @(negedge clk);
        e.kind = K_MOVE; e.player = 1'b1; e.pos = 9'h100;
        exp_q.push_back(e);
        btn_x_raw = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!move_req && n < 40);
        chk("req_seen_before_reset", move_req, 1);
        @(negedge clk);
        reset = 1'b1;
        btn_x_raw = 1'b0;
        @(negedge clk);
        chk("reset_drops_req", move_req, 0);
        chk("reset_clears_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int          who;
        logic        tx;
        logic        to_;
        logic [8:0]  sel;
        int          r;
        int          d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_move_req", move_req, 0);
        chk("reset_move_player", move_player, 0);
        chk("reset_move_pos", move_pos, 0);
        chk("reset_bad_sel", bad_sel, 0);
        chk("reset_ack_timeout", ack_timeout, 0);
        chk("reset_busy", busy, 0);
        chk("reset_flash_clk", flash_clk, 0);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk("flash_clk", flash_clk, (k / FD) % 2);
        end

        do_move(0, 9'h010, 1'b1, 1'b0, 2, 1'b0, 3);
        do_move(0, 9'h010, 1'b1, 1'b0, 1, 1'b1, 50);
        do_move(0, 9'h011, 1'b1, 1'b0, 0, 1'b0, 2);
        do_move(0, 9'h004, 1'b1, 1'b0, 20, 1'b0, 2);
        do_move(1, 9'h080, 1'b0, 1'b1, 15, 1'b0, 2);
        do_move(2, 9'h001, 1'b0, 1'b1, 3, 1'b0, 2);
        do_move(2, 9'h020, 1'b0, 1'b0, 0, 1'b0, 1);
        reset_during_req();

        for (int t = 0; t < 40; t++) begin
            who = $urandom_range(0, 2);
            tx  = 1'($urandom_range(0, 1));
            to_ = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do begin
                    sel = 9'($urandom_range(0, 511));
                end while ($countones(sel) == 1);
            end else begin
                sel = 9'(1 << $urandom_range(0, 8));
            end
            r = $urandom_range(0, 9);
            if (r < 6) d = $urandom_range(0, 14);
            else if (r < 8) d = 15;
            else d = $urandom_range(16, 20);
            do_move(who, sel, tx, to_, d, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
